pipe_hazard_ctrl: RTL and testbench

Central hazard controller for the 8-bit five-stage pipeline (F, D, E, M, W). It generates the stall and flush controls for the pipeline latches, including the F→D latch's `StallD` and `FlushD`. It also produces the Execute-stage forwarding selects. It sequences three multi-cycle events: data-memory wait states with a timeout, HALT drain, and the halted condition.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_fwd.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline hazard logic.
//   hzState_t     : hazard controller FSM states
//   FWD_RF/W/M    : Execute-stage forwarding select encodings
//   REG_W_DEFAULT : default register-index width
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED
  } hzState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int unsigned REG_W_DEFAULT = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Forwarding compare for one Execute-stage source operand.
//   rsE                  : Execute source register index
//   rdM, regWriteM       : Memory-stage destination / write enable
//   rdW, regWriteW       : Writeback-stage destination / write enable
//   fwdSel               : FWD_M, FWD_W or FWD_RF (M has priority)
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  output logic [1:0]       fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 8-bit F/D/E/M/W pipeline.
// Produces latch stall/flush controls and Execute forwarding selects, and
// sequences memory wait states (with timeout), HALT drain and halted state.
//   clk, rst                      : clock, synchronous active-high reset
//   rs1D, rs2D                    : Decode sources
//   rs1E, rs2E, rdE               : Execute sources / destination
//   regWriteE, memToRegE          : Execute writes reg / is a load
//   rdM, regWriteM, rdW, regWriteW: M and W destinations / write enables
//   branchTakenE                  : taken branch resolved in Execute
//   memReqM, memReadyM            : Memory-stage request / ready
//   haltD                         : HALT in Decode
//   StallF/D/E/M, FlushD/E/W      : latch controls
//   ForwardAE, ForwardBE          : operand forwarding selects
//   halted, memFault              : halted flag, one-cycle timeout pulse
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEFAULT,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  input  logic             branchTakenE,
  input  logic             memReqM,
  input  logic             memReadyM,
  input  logic             haltD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             halted,
  output logic             memFault
);

  localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  hzState_t            state, stateNext;
  logic [WAIT_W-1:0]   waitCnt, waitCntNext;
  logic [DRAIN_W-1:0]  drainCnt, drainCntNext;
  logic                retDrain, retDrainNext;
  logic                faultQ, faultNext;

  logic       memStall, lwStall, draining;
  logic [1:0] fwdA, fwdB;

  // regWriteE is part of the Execute bundle but a load always writes, so
  // memToRegE alone qualifies the load-use check.
  logic unusedRegWriteE;
  assign unusedRegWriteE = regWriteE;

  assign memStall = memReqM && !memReadyM;
  assign lwStall  = memToRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
  // A memory wait that interrupted a drain keeps draining once memory is ready.
  assign draining = (state == DRAIN) || ((state == MEM_WAIT) && retDrain);

  fwd_unit #(.REG_W(REG_W)) fwdUnitA (
    .rsE(rs1E), .rdM(rdM), .regWriteM(regWriteM),
    .rdW(rdW), .regWriteW(regWriteW), .fwdSel(fwdA)
  );

  fwd_unit #(.REG_W(REG_W)) fwdUnitB (
    .rsE(rs2E), .rdM(rdM), .regWriteM(regWriteM),
    .rdW(rdW), .regWriteW(regWriteW), .fwdSel(fwdB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      waitCnt  <= '0;
      drainCnt <= '0;
      retDrain <= 1'b0;
      faultQ   <= 1'b0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitCntNext;
      drainCnt <= drainCntNext;
      retDrain <= retDrainNext;
      faultQ   <= faultNext;
    end
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    drainCntNext = drainCnt;
    retDrainNext = retDrain;
    faultNext    = 1'b0;
    unique case (state)
      RUN: begin
        if (memStall) begin
          stateNext    = MEM_WAIT;
          waitCntNext  = WAIT_W'(1);
          retDrainNext = 1'b0;
        end else if (haltD && !branchTakenE && !lwStall) begin
          stateNext    = DRAIN;
          drainCntNext = '0;
        end
      end
      DRAIN: begin
        if (memStall) begin
          stateNext    = MEM_WAIT;
          waitCntNext  = WAIT_W'(1);
          retDrainNext = 1'b1;
        end else if (drainCnt == DRAIN_LAST) begin
          stateNext = HALTED;
        end else begin
          drainCntNext = drainCnt + 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memStall) begin
          if (waitCnt == WAIT_LAST) begin
            stateNext = HALTED;
            faultNext = 1'b1;
          end else if (waitCnt != '1) begin
            waitCntNext = waitCnt + 1'b1;
          end
        end else begin
          waitCntNext  = '0;
          retDrainNext = 1'b0;
          // The ready cycle of an interrupted drain is itself a drain bubble,
          // so a stall of N cycles delays halting by exactly N cycles.
          if (retDrain) begin
            if (drainCnt == DRAIN_LAST) begin
              stateNext = HALTED;
            end else begin
              stateNext    = DRAIN;
              drainCntNext = drainCnt + 1'b1;
            end
          end else begin
            stateNext = RUN;
          end
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwdA;
    ForwardBE = fwdB;
    halted    = 1'b0;
    memFault  = 1'b0;
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else begin
      memFault = faultQ;
      if (state == HALTED) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        halted = 1'b1;
      end else if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (draining) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (branchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int RW = 3;
  localparam int TO = 16;
  localparam int DC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteE, memToRegE, regWriteM, regWriteW;
  logic branchTakenE, memReqM, memReadyM, haltD;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic halted, memFault;

  pipe_hazard_ctrl #(.REG_W(RW), .MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regWriteE(regWriteE), .memToRegE(memToRegE),
    .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW), .regWriteW(regWriteW),
    .branchTakenE(branchTakenE), .memReqM(memReqM), .memReadyM(memReadyM),
    .haltD(haltD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .halted(halted), .memFault(memFault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts instead of states: remaining drain bubbles, length of the current
  // memory-stall run, halted flag and pending fault pulse.
  bit mHalted = 0;
  bit mFault  = 0;
  int mDrainLeft = 0;
  int mWaitRun   = 0;

  function automatic int fwdExp(input int rs);
    if (regWriteM && rdM != 0 && int'(rdM) == rs) return 2;
    if (regWriteW && rdW != 0 && int'(rdW) == rs) return 1;
    return 0;
  endfunction

  function automatic bit mStallNow();
    return memReqM && !memReadyM;
  endfunction

  function automatic bit loadUseNow();
    return memToRegE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mHalted    <= 0;
      mFault     <= 0;
      mDrainLeft <= 0;
      mWaitRun   <= 0;
    end else begin
      mFault <= 0;
      if (!mHalted) begin
        if (mStallNow()) begin
          if (mWaitRun + 1 == TO) begin
            mHalted  <= 1;
            mFault   <= 1;
            mWaitRun <= 0;
          end else begin
            mWaitRun <= mWaitRun + 1;
          end
        end else begin
          mWaitRun <= 0;
          if (mDrainLeft > 0) begin
            mDrainLeft <= mDrainLeft - 1;
            if (mDrainLeft == 1) mHalted <= 1;
          end else if (haltD && !branchTakenE && !loadUseNow() && mWaitRun == 0) begin
            mDrainLeft <= DC;
          end
        end
      end
    end
  end

  bit eSF, eSD, eSE, eSM, eFD, eFE, eFW, eH, eMF;
  int eFA, eFB;

  always @(negedge clk) begin
    {eSF, eSD, eSE, eSM, eFD, eFE, eFW, eH, eMF} = '0;
    eFA = 0;
    eFB = 0;
    if (rst) begin
      eFD = 1; eFE = 1; eFW = 1;
    end else begin
      eFA = fwdExp(int'(rs1E));
      eFB = fwdExp(int'(rs2E));
      eH  = mHalted;
      eMF = mFault;
      if (mHalted) begin
        eSF = 1; eSD = 1; eFE = 1;
      end else if (mStallNow()) begin
        eSF = 1; eSD = 1; eSE = 1; eSM = 1; eFW = 1;
      end else if (mDrainLeft > 0) begin
        eSF = 1; eSD = 1; eFE = 1;
      end else if (branchTakenE) begin
        eFD = 1; eFE = 1;
      end else if (loadUseNow()) begin
        eSF = 1; eSD = 1; eFE = 1;
      end
    end
    chk("StallF", StallF, eSF);
    chk("StallD", StallD, eSD);
    chk("StallE", StallE, eSE);
    chk("StallM", StallM, eSM);
    chk("FlushD", FlushD, eFD);
    chk("FlushE", FlushE, eFE);
    chk("FlushW", FlushW, eFW);
    chk("ForwardAE", ForwardAE, eFA);
    chk("ForwardBE", ForwardBE, eFB);
    chk("halted", halted, eH);
    chk("memFault", memFault, eMF);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regWriteE = 0; memToRegE = 0; regWriteM = 0; regWriteW = 0;
    branchTakenE = 0; memReqM = 0; memReadyM = 0; haltD = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1;
    idle();
    step();
    rst = 0;
  endtask

  int cnt;
  int edges;

  initial begin
    rst = 1;
    idle();
    #1;
    step();
    #3;
    chk("rstFlushD", FlushD, 1);
    chk("rstFlushW", FlushW, 1);
    chk("rstStallF", StallF, 0);
    chk("rstHalted", halted, 0);
    step();
    rst = 0;

    // forwarding
    rs1E = 3; rdM = 3; regWriteM = 1; rdW = 3; regWriteW = 1;
    #3; chk("fwdA_M", ForwardAE, 2'b10);
    step();
    rdM = 0;
    #3; chk("fwdA_W", ForwardAE, 2'b01);
    step();
    rs1E = 0;
    #3; chk("fwdA_RF", ForwardAE, 2'b00);
    step();
    rs2E = 5; rdM = 5; rdW = 5;
    #3; chk("fwdB_M", ForwardBE, 2'b10);
    step();
    regWriteM = 0;
    #3; chk("fwdB_W", ForwardBE, 2'b01);
    step();
    idle();

    // load-use, then load-use suppressed by taken branch
    memToRegE = 1; rdE = 2; rs2D = 2;
    #3; chk("luStallF", StallF, 1); chk("luFlushE", FlushE, 1); chk("luFlushD", FlushD, 0);
    step();
    idle();
    #3; chk("luOneBubble", StallF, 0);
    step();
    memToRegE = 1; rdE = 2; rs2D = 2; branchTakenE = 1;
    #3; chk("brFlushD", FlushD, 1); chk("brFlushE", FlushE, 1); chk("brStallF", StallF, 0);
    step();
    idle();

    // memory wait of 5 cycles
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      memReqM = 1; memReadyM = 0;
      #3; if (StallM && StallF && FlushW) cnt++;
      step();
    end
    memReadyM = 1;
    #3; chk("memReadyNoStall", StallM, 0);
    step();
    idle();
    chk("memWaitCycles", cnt, 5);
    #3; chk("memWaitNoFault", memFault, 0); chk("memWaitRun", StallF, 0);
    step();

    // halt with a 2-cycle memory stall inside the drain
    haltD = 1;
    #3; chk("haltNoStall", StallF, 0);
    step();
    haltD = 0;
    edges = 1;
    #3; chk("drainFlushE", FlushE, 1);
    step(); edges++;
    memReqM = 1; memReadyM = 0;
    #3; chk("drainMemStall", StallM, 1);
    step(); edges++;
    step(); edges++;
    memReadyM = 1;
    #3; chk("drainReadyBubble", FlushE, 1);
    step(); edges++;
    idle();
    for (int i = 0; i < 20; i++) begin
      #3;
      if (halted) break;
      step(); edges++;
    end
    chk("haltEdgesWithStall", edges, DC + 1 + 2);

    // reset out of HALTED
    rst = 1;
    #3; chk("rstFromHaltedH", halted, 0); chk("rstFromHaltedFD", FlushD, 1);
    step();
    rst = 0;
    #3; chk("runAfterRstH", halted, 0); chk("runAfterRstSF", StallF, 0);
    step();

    // plain halt
    haltD = 1;
    step();
    haltD = 0;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (halted) break;
      step(); edges++;
    end
    chk("haltEdges", edges, DC + 1);
    doReset();

    // memory timeout
    memReqM = 1; memReadyM = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (memFault) break;
      if (StallM) cnt++;
      step();
    end
    chk("timeoutStalls", cnt, TO);
    chk("timeoutFault", memFault, 1);
    chk("timeoutHalted", halted, 1);
    step();
    #3; chk("faultPulseEnds", memFault, 0); chk("haltedStays", halted, 1);
    step();
    step();
    #3; chk("haltedStays2", halted, 1);
    doReset();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
